saradc_ctrl_mc: RTL and testbench
=================================

SARADC_CTRL_MC -- requirements
Module: saradc_ctrl_mc

Interface
REQ-001 SHALL have parameter NBITS, default 8, meaning conversion resolution in bits (range 4..12).
REQ-002 SHALL have parameter NCH, default 4, meaning number of input channels (range 1..16).
REQ-003 SHALL have parameter NSAMP, default 2, meaning sampling-phase length in CLK cycles (range 1..15).
REQ-004 SHALL have port CLK  input  1  conversion clock; all state changes on its rising edge.
REQ-005 SHALL have port RSTN  input  1  asynchronous active-low reset.
REQ-006 SHALL have port START  input  1  scan request pulse or level.
REQ-007 SHALL have port CH_MASK  input  NCH  channels to convert in this scan.
REQ-008 SHALL have port CMPO  input  1  comparator decision, 1 = VOUTH above VOUTL.
REQ-009 SHALL have port SAMPLE  output  1  to S&H; high during sampling phase.
REQ-010 SHALL have port RESULTP  output  NBITS  CDAC positive control word.
REQ-011 SHALL have port RESULTN  output  NBITS  CDAC negative control word.
REQ-012 SHALL have port VALID  output  1  one-cycle pulse when a conversion finishes.
REQ-013 SHALL have port CH_SEL  output  max(1,clog2(NCH))  analog mux channel index.
REQ-014 SHALL have port DOUT  output  NBITS  converted code.
REQ-015 SHALL have port DOUT_CH  output  max(1,clog2(NCH))  channel of DOUT.
REQ-016 SHALL have port DOUT_VALID  output  1  DOUT/DOUT_CH valid.
REQ-017 SHALL have port DOUT_READY  input  1  consumer accepts DOUT.
REQ-018 SHALL have port BUSY  output  1  high whenever state is not IDLE.

Function
REQ-019 SHALL implement states IDLE, SMP, CONV, HOLD.
REQ-020 SHALL, in IDLE with START=1 and CH_MASK!=0, latch CH_MASK, set CH_SEL to lowest set bit, enter SMP; START with CH_MASK=0 or outside IDLE SHALL be ignored.
REQ-021 SHALL hold SAMPLE=1 for exactly NSAMP cycles in SMP, clear RESULTP/RESULTN to 0 on SMP entry, then enter CONV.
REQ-022 SHALL, in CONV cycle k (k=0..NBITS-1, bit i=NBITS-1-k), register RESULTP[i]<=CMPO and RESULTN[i]<=~CMPO; undecided bits stay 0 in both words.
REQ-023 SHALL, at the edge deciding bit 0, pulse VALID for one cycle, load DOUT with the final RESULTP value, DOUT_CH with CH_SEL, assert DOUT_VALID, enter HOLD.
REQ-024 SHALL hold DOUT, DOUT_CH, DOUT_VALID stable in HOLD until DOUT_READY=1; no new sample starts while DOUT_VALID=1 and DOUT_READY=0.
REQ-025 SHALL, on DOUT_VALID&&DOUT_READY, clear DOUT_VALID and advance to next higher latched channel (enter SMP) or, if none, enter IDLE.
REQ-026 SHALL yield start-to-first-DOUT_VALID latency of 1+NSAMP+NBITS cycles (single conversion per channel).
REQ-027 SHALL keep CH_SEL constant from SMP entry through HOLD exit of that channel.

Reset
REQ-028 SHALL, on RSTN=0, asynchronously force state IDLE, SAMPLE=0, RESULTP=0, RESULTN=0, VALID=0, CH_SEL=0, DOUT=0, DOUT_CH=0, DOUT_VALID=0, BUSY=0, latched mask=0.
REQ-029 SHALL abandon any in-progress conversion on reset mid-scan without emitting DOUT_VALID; first START after release behaves per REQ-020.

Configuration
REQ-030 SHALL, with macro SARADC_OVERSAMPLE_EN defined, add parameter NOSR (default 2) and perform 2^NOSR back-to-back SMP+CONV cycles per channel, accumulating RESULTP into an NBITS+NOSR accumulator, DOUT = accumulator>>NOSR (truncate), VALID pulsing per individual conversion, DOUT_VALID once per channel.
REQ-031 SHALL, without SARADC_OVERSAMPLE_EN, contain no accumulator or NOSR parameter and behave per REQ-019..REQ-027.

Structure
REQ-032 SHALL place state enum, channel-index width function and oversampling constants in shared package saradc_ctrl_pkg.
REQ-033 SHALL implement bit-pointer and RESULTP/RESULTN registers in sub-module saradc_sar_reg; FSM, channel sequencer and output register in saradc_ctrl_mc.

Verification
REQ-034 SHALL cover: NBITS=8, CH_MASK=4'b0001, CMPO model of code 8'hA5, DOUT_READY=1 -> DOUT=8'hA5, DOUT_CH=0, DOUT_VALID 11 cycles after START (NSAMP=2), RESULTN=8'h5A.
REQ-035 SHALL cover: CH_MASK=4'b1010, codes 8'h00 and 8'hFF -> DOUT_CH sequence 1 then 3, DOUT 8'h00 then 8'hFF, then IDLE, BUSY=0.
REQ-036 SHALL cover: DOUT_READY=0 for 20 cycles after DOUT_VALID -> DOUT stable, SAMPLE stays 0, next channel starts only after READY=1.
REQ-037 SHALL cover: START with CH_MASK=0, and START during CONV -> no state change, no extra DOUT_VALID.
REQ-038 SHALL cover: RSTN=0 asserted in CONV bit 4 -> all outputs 0 immediately; restart yields correct code.
REQ-039 SHALL cover with SARADC_OVERSAMPLE_EN, NOSR=2: codes 8'h10,8'h11,8'h12,8'h13 -> four VALID pulses, one DOUT_VALID, DOUT=8'h11.

Source files
------------

// File: rtl/saradc_ctrl_pkg.sv
// Shared types and constants for the SAR ADC multi-channel controller:
// FSM state encoding, channel-index width helper, oversampling constants.
package saradc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SMP  = 2'd1,
        ST_CONV = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam int SMP_CNT_W    = 4;
    localparam int NOSR_DEFAULT = 2;

    function automatic int ch_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    function automatic int osr_cnt_width(input int nosr);
        return (nosr > 1) ? nosr : 1;
    endfunction

endpackage

// File: rtl/saradc_ctrl_mc_if.sv
// Result stream of the SAR ADC controller: converted code, its channel and
// a valid/ready handshake toward the consumer.
interface saradc_ctrl_mc_if
    import saradc_ctrl_pkg::*;
#(
    parameter int NBITS = 8,
    parameter int NCH   = 4
);
    logic [NBITS-1:0]        dout;
    logic [ch_width(NCH)-1:0] dout_ch;
    logic                    dout_valid;
    logic                    dout_ready;

    modport master (output dout, dout_ch, dout_valid, input dout_ready);
    modport slave  (input dout, dout_ch, dout_valid, output dout_ready);
endinterface

// File: rtl/saradc_sar_reg.sv
// Successive-approximation register: MSB-first bit pointer plus the
// complementary CDAC control words built from comparator decisions.
module saradc_sar_reg #(
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic             en,
    input  logic             cmpo,
    output logic [NBITS-1:0] resultp,
    output logic [NBITS-1:0] resultn,
    output logic [NBITS-1:0] final_word,
    output logic             last
);
    localparam int BW = $clog2(NBITS);

    logic [BW-1:0] bit_idx;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bit_idx <= '0;
            resultp <= '0;
            resultn <= '0;
        end else if (clear) begin
            bit_idx <= BW'(NBITS - 1);
            resultp <= '0;
            resultn <= '0;
        end else if (en) begin
            resultp[bit_idx] <= cmpo;
            resultn[bit_idx] <= ~cmpo;
            if (bit_idx != '0)
                bit_idx <= bit_idx - BW'(1);
        end
    end

    assign last = (bit_idx == '0);
    // Word as it will read once the bit-0 decision currently on cmpo lands.
    assign final_word = {resultp[NBITS-1:1], cmpo};

endmodule

// File: rtl/saradc_ctrl_mc.sv
// Multi-channel SAR ADC conversion controller: scan sequencer, sample/convert
// FSM and result output register. Optional build macro SARADC_OVERSAMPLE_EN
// averages 2^NOSR conversions per channel.
//
// state   | meaning
// IDLE    | waiting for START with a non-empty channel mask
// SMP     | S&H tracking the selected channel for NSAMP cycles
// CONV    | one comparator decision per cycle, MSB first
// HOLD    | result presented, waiting for the consumer to accept it
module saradc_ctrl_mc
    import saradc_ctrl_pkg::*;
#(
    parameter int NBITS = 8,
    parameter int NCH   = 4,
    parameter int NSAMP = 2
`ifdef SARADC_OVERSAMPLE_EN
    ,
    parameter int NOSR  = NOSR_DEFAULT
`endif
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start,
    input  logic [NCH-1:0]           ch_mask,
    input  logic                     cmpo,
    output logic                     sample,
    output logic [NBITS-1:0]         resultp,
    output logic [NBITS-1:0]         resultn,
    output logic                     valid,
    output logic [ch_width(NCH)-1:0] ch_sel,
    output logic                     busy,
    saradc_ctrl_mc_if.master         dout_if
);
    localparam int CHW = ch_width(NCH);

    state_t                 state, state_nxt;
    logic [SMP_CNT_W-1:0]   smp_cnt;
    logic [NCH-1:0]         mask_q;
    logic [CHW-1:0]         first_ch, next_ch;
    logic                   has_next;
    logic                   sar_clear, sar_en, last, conv_done, osr_done;
    logic [NBITS-1:0]       final_word, dout_load, dout_q;
    logic [CHW-1:0]         dout_ch_q;
    logic                   dout_valid_q;

    saradc_sar_reg #(.NBITS(NBITS)) u_sar_reg (
        .clk        (clk),
        .rstn       (rstn),
        .clear      (sar_clear),
        .en         (sar_en),
        .cmpo       (cmpo),
        .resultp    (resultp),
        .resultn    (resultn),
        .final_word (final_word),
        .last       (last)
    );

    // Descending scan leaves the lowest qualifying index in each result.
    always_comb begin
        first_ch = '0;
        next_ch  = '0;
        has_next = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (ch_mask[i])
                first_ch = CHW'(i);
            if (mask_q[i] && (i > int'(ch_sel))) begin
                next_ch  = CHW'(i);
                has_next = 1'b1;
            end
        end
    end

`ifdef SARADC_OVERSAMPLE_EN
    localparam int OSR_W = osr_cnt_width(NOSR);

    logic [NBITS+NOSR-1:0] acc, acc_sum;
    logic [OSR_W-1:0]      osr_cnt;
    logic                  ch_start;

    assign ch_start  = sar_clear && ((state == ST_IDLE) || (state == ST_HOLD));
    assign acc_sum   = acc + {{NOSR{1'b0}}, final_word};
    assign dout_load = acc_sum[NBITS+NOSR-1:NOSR];
    assign osr_done  = (osr_cnt == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc     <= '0;
            osr_cnt <= '0;
        end else if (ch_start) begin
            acc     <= '0;
            osr_cnt <= OSR_W'((1 << NOSR) - 1);
        end else if (conv_done) begin
            acc <= acc_sum;
            if (osr_cnt != '0)
                osr_cnt <= osr_cnt - OSR_W'(1);
        end
    end
`else
    assign dout_load = final_word;
    assign osr_done  = 1'b1;
`endif

    assign conv_done = (state == ST_CONV) && last;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start && (ch_mask != '0)) state_nxt = ST_SMP;
            ST_SMP:  if (smp_cnt == '0)            state_nxt = ST_CONV;
            ST_CONV: if (last)                     state_nxt = osr_done ? ST_HOLD : ST_SMP;
            ST_HOLD: if (dout_if.dout_ready)       state_nxt = has_next ? ST_SMP : ST_IDLE;
            default:                               state_nxt = ST_IDLE;
        endcase
    end

    assign sar_clear = (state_nxt == ST_SMP) && (state != ST_SMP);
    assign sar_en    = (state == ST_CONV);
    assign sample    = (state == ST_SMP);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            smp_cnt      <= '0;
            mask_q       <= '0;
            ch_sel       <= '0;
            valid        <= 1'b0;
            dout_q       <= '0;
            dout_ch_q    <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            valid <= conv_done;
            if ((state == ST_IDLE) && (state_nxt == ST_SMP)) begin
                mask_q <= ch_mask;
                ch_sel <= first_ch;
            end else if ((state == ST_HOLD) && (state_nxt == ST_SMP)) begin
                ch_sel <= next_ch;
            end else if ((state == ST_HOLD) && (state_nxt == ST_IDLE)) begin
                mask_q <= '0;
            end
            if (sar_clear)
                smp_cnt <= SMP_CNT_W'(NSAMP - 1);
            else if ((state == ST_SMP) && (smp_cnt != '0))
                smp_cnt <= smp_cnt - SMP_CNT_W'(1);
            if (conv_done && osr_done) begin
                dout_q       <= dout_load;
                dout_ch_q    <= ch_sel;
                dout_valid_q <= 1'b1;
            end else if ((state == ST_HOLD) && dout_if.dout_ready) begin
                dout_valid_q <= 1'b0;
            end
        end
    end

    assign dout_if.dout       = dout_q;
    assign dout_if.dout_ch    = dout_ch_q;
    assign dout_if.dout_valid = dout_valid_q;

endmodule

// File: tb/tb_saradc_ctrl_mc.sv
// Directed bench for saradc_ctrl_mc with a per-conversion comparator model
// (SARADC_OVERSAMPLE_EN adds the averaging scenario).
module tb_saradc_ctrl_mc;
    localparam int NBITS = 8;
    localparam int NCH   = 4;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             start = 1'b0;
    logic [NCH-1:0]   ch_mask = '0;
    logic             cmpo = 1'b0;
    logic             sample, valid, busy;
    logic [NBITS-1:0] resultp, resultn;
    logic [1:0]       ch_sel;

    int n_cmp = 0;
    int n_err = 0;
    int vcnt  = 0;
    int dvcnt = 0;
    int lat;

    // Comparator model state; conv_num and cnt are written only by the model.
    logic [NBITS-1:0] code_list [16];
    logic [NBITS-1:0] cur_code = '0;
    int               conv_num = 0;
    int               cnt = 99;
    logic             in_smp = 1'b0;

    saradc_ctrl_mc_if #(.NBITS(NBITS), .NCH(NCH)) dif ();

    saradc_ctrl_mc #(
        .NBITS(NBITS),
        .NCH  (NCH),
        .NSAMP(2)
`ifdef SARADC_OVERSAMPLE_EN
        ,
        .NOSR (2)
`endif
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .ch_mask (ch_mask),
        .cmpo    (cmpo),
        .sample  (sample),
        .resultp (resultp),
        .resultn (resultn),
        .valid   (valid),
        .ch_sel  (ch_sel),
        .busy    (busy),
        .dout_if (dif.master)
    );

    always #5 clk = ~clk;

    // Each conversion takes the next code from code_list; during CONV cycle k
    // the comparator answers with bit NBITS-1-k of that code.
    always @(negedge clk) begin
        if (sample) begin
            if (!in_smp) begin
                cur_code = code_list[conv_num];
                conv_num = conv_num + 1;
                in_smp   = 1'b1;
            end
            cnt = 0;
        end else begin
            in_smp = 1'b0;
            if (cnt <= NBITS)
                cnt = cnt + 1;
        end
        cmpo = (cnt >= 1 && cnt <= NBITS) ? cur_code[NBITS-cnt] : 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [NCH-1:0] m);
        start   = 1'b1;
        ch_mask = m;
        step();
        start   = 1'b0;
    endtask

    // Edges until dout_valid, or -1 once the budget runs out.
    task automatic wait_dv(output int n);
        n    = -1;
        vcnt = 0;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (valid) vcnt++;
            if (dif.dout_valid) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        code_list[0]  = 8'hA5; code_list[1]  = 8'h00; code_list[2]  = 8'hFF;
        code_list[3]  = 8'h3C; code_list[4]  = 8'hC3; code_list[5]  = 8'h66;
        code_list[6]  = 8'hE7; code_list[7]  = 8'h5A; code_list[8]  = 8'h10;
        code_list[9]  = 8'h11; code_list[10] = 8'h12; code_list[11] = 8'h13;
        for (int i = 12; i < 16; i++) code_list[i] = '0;
        dif.dout_ready = 1'b1;

        // Reset values
        repeat (3) step();
        chk("rst_sample", sample, 0);
        chk("rst_resultp", resultp, 0);
        chk("rst_resultn", resultn, 0);
        chk("rst_valid", valid, 0);
        chk("rst_ch_sel", ch_sel, 0);
        chk("rst_dout", dif.dout, 0);
        chk("rst_dout_ch", dif.dout_ch, 0);
        chk("rst_dout_valid", dif.dout_valid, 0);
        chk("rst_busy", busy, 0);
        rstn = 1'b1;
        step();

        // Single channel 0, code A5, latency 1+NSAMP+NBITS
        kick(4'b0001);
        chk("t1_sample", sample, 1);
        chk("t1_busy", busy, 1);
        chk("t1_ch_sel", ch_sel, 0);
        wait_dv(lat);
        chk("t1_latency", lat + 1, 11);
        chk("t1_dout", dif.dout, 8'hA5);
        chk("t1_dout_ch", dif.dout_ch, 0);
        chk("t1_resultp", resultp, 8'hA5);
        chk("t1_resultn", resultn, 8'h5A);
        chk("t1_valid", valid, 1);
        step();
        chk("t1_valid_pulse", valid, 0);
        chk("t1_dv_clear", dif.dout_valid, 0);
        chk("t1_idle", busy, 0);

        // Mask 1010: channels 1 then 3, codes 00 then FF
        kick(4'b1010);
        chk("t2_first_ch", ch_sel, 1);
        wait_dv(lat);
        chk("t2_lat_a", lat, 10);
        chk("t2_dout_a", dif.dout, 8'h00);
        chk("t2_dout_ch_a", dif.dout_ch, 1);
        step();
        chk("t2_next_ch", ch_sel, 3);
        chk("t2_next_sample", sample, 1);
        chk("t2_dv_clear", dif.dout_valid, 0);
        wait_dv(lat);
        chk("t2_lat_b", lat, 10);
        chk("t2_dout_b", dif.dout, 8'hFF);
        chk("t2_dout_ch_b", dif.dout_ch, 3);
        step();
        chk("t2_busy", busy, 0);
        chk("t2_dv_end", dif.dout_valid, 0);

        // Back-pressure: ready low for 20 cycles holds the result
        dif.dout_ready = 1'b0;
        kick(4'b0101);
        wait_dv(lat);
        chk("t3_dout_a", dif.dout, 8'h3C);
        chk("t3_dout_ch_a", dif.dout_ch, 0);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t3_hold_dout", dif.dout, 8'h3C);
            chk("t3_hold_sample", sample, 0);
            chk("t3_hold_dv", dif.dout_valid, 1);
        end
        dif.dout_ready = 1'b1;
        step();
        chk("t3_release_dv", dif.dout_valid, 0);
        chk("t3_release_sample", sample, 1);
        chk("t3_release_ch", ch_sel, 2);
        wait_dv(lat);
        chk("t3_lat_b", lat, 10);
        chk("t3_dout_b", dif.dout, 8'hC3);
        chk("t3_dout_ch_b", dif.dout_ch, 2);
        step();
        chk("t3_busy", busy, 0);

        // START with empty mask, then START during CONV
        start   = 1'b1;
        ch_mask = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_empty_busy", busy, 0);
            chk("t4_empty_sample", sample, 0);
        end
        start = 1'b0;
        kick(4'b0001);
        repeat (3) step();
        start   = 1'b1;
        ch_mask = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_conv_busy", busy, 1);
            chk("t4_conv_ch", ch_sel, 0);
            chk("t4_conv_sample", sample, 0);
        end
        start   = 1'b0;
        ch_mask = 4'b0001;
        wait_dv(lat);
        chk("t4_lat", lat, 4);
        chk("t4_dout", dif.dout, 8'h66);
        chk("t4_dout_ch", dif.dout_ch, 0);
        step();
        chk("t4_busy", busy, 0);
        dvcnt = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (dif.dout_valid) dvcnt++;
        end
        chk("t4_no_extra_dv", dvcnt, 0);
        chk("t4_conv_count", conv_num, 6);

        // Reset while deciding bit 4, then restart
        kick(4'b0100);
        repeat (5) step();
        chk("t5_partial", resultp, 8'hE0);
        chk("t5_ch_sel", ch_sel, 2);
        rstn = 1'b0;
        #1;
        chk("t5_rst_sample", sample, 0);
        chk("t5_rst_resultp", resultp, 0);
        chk("t5_rst_resultn", resultn, 0);
        chk("t5_rst_ch_sel", ch_sel, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_dout", dif.dout, 0);
        chk("t5_rst_dv", dif.dout_valid, 0);
        repeat (2) step();
        rstn = 1'b1;
        dvcnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (dif.dout_valid) dvcnt++;
        end
        chk("t5_no_dv", dvcnt, 0);
        kick(4'b0100);
        wait_dv(lat);
        chk("t5_lat", lat + 1, 11);
        chk("t5_dout", dif.dout, 8'h5A);
        chk("t5_dout_ch", dif.dout_ch, 2);
        step();
        chk("t5_busy", busy, 0);

`ifdef SARADC_OVERSAMPLE_EN
        // Four conversions on channel 1, codes 10..13, average 11
        kick(4'b0010);
        wait_dv(lat);
        chk("t6_lat", lat, 40);
        chk("t6_valid_count", vcnt, 4);
        chk("t6_dout", dif.dout, 8'h11);
        chk("t6_dout_ch", dif.dout_ch, 1);
        step();
        chk("t6_dv_clear", dif.dout_valid, 0);
        chk("t6_busy", busy, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
